// File: rtl/override_pkg.sv
// Shared types and defaults for the override scheduler.
//   ovr_state_e : scheduler FSM state (IDLE / HOLD / GAP)
//   ovr_req_t   : override request {value, hold} at default widths
package override_pkg;

  localparam int OVR_WIDTH_DEF = 4;
  localparam int OVR_CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } ovr_state_e;

  typedef struct packed {
    logic [OVR_WIDTH_DEF-1:0] value;
    logic [OVR_CNT_W_DEF-1:0] hold;
  } ovr_req_t;

endpackage

// File: rtl/override_pend_slot.sv
// One-entry holding register for a queued override request.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : capture i_data, mark valid
//   i_flush      : drop any held entry (wins over load/take)
//   i_take       : consumer takes the entry, mark empty
//   o_valid      : entry held
//   o_data       : held entry
module override_pend_slot #(
  parameter int DW = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic          i_flush,
  input  logic          i_take,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (i_flush)     r_valid <= 1'b0;
      else if (i_load) r_valid <= 1'b1;
      else if (i_take) r_valid <= 1'b0;
      if (i_load) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/override_scheduler.sv
// Sequencer for the procedural-override register stage. Accepts {value, hold}
// requests over valid/ready, drives force_en/force_val for max(hold,1) cycles,
// then releases for exactly one GAP cycle (done pulse). One pending request
// can be queued during HOLD so back-to-back overrides need no stall.
//   clock, reset        : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready is combinational)
//   req_value, req_hold : value to force, cycles to hold (0 treated as 1)
//   cancel              : abort active override, flush pending slot
//   force_en, force_val : registered override controls for downstream
//   busy                : combinational, state != IDLE or pending valid
//   done, done_cancelled: registered end-of-override pulse and its cause
module override_scheduler
  import override_pkg::*;
#(
  parameter int WIDTH = OVR_WIDTH_DEF,
  parameter int CNT_W = OVR_CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_value,
  input  logic [CNT_W-1:0] req_hold,
  input  logic             cancel,
  output logic             force_en,
  output logic [WIDTH-1:0] force_val,
  output logic             busy,
  output logic             done,
  output logic             done_cancelled
);

  ovr_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_force_en, r_done, r_done_cancelled;
  logic [WIDTH-1:0]   r_force_val;

  logic               w_accept, w_pend_valid, w_pend_load, w_pend_take;
  logic [WIDTH+CNT_W-1:0] w_pend_data;
  logic               w_load_req, w_load_pend, w_cancel_exit;
  logic [WIDTH-1:0]   w_src_value;
  logic [CNT_W-1:0]   w_src_hold, w_cnt_init;
  logic               w_force_en_nxt, w_done_nxt, w_done_cancelled_nxt;
  logic [WIDTH-1:0]   w_force_val_nxt;

  // cancel blocks acceptance so it always wins over a new request
  assign req_ready = !reset && !w_pend_valid && !cancel;
  assign w_accept  = req_valid && req_ready;

  // Requests arriving during HOLD queue; IDLE/GAP accepts bypass the slot.
  assign w_pend_load = w_accept && (r_state == HOLD);
  assign w_pend_take = w_load_pend;

  override_pend_slot #(.DW(WIDTH + CNT_W)) u_pend (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_load  (w_pend_load),
    .i_flush (cancel),
    .i_take  (w_pend_take),
    .i_data  ({req_value, req_hold}),
    .o_valid (w_pend_valid),
    .o_data  (w_pend_data)
  );

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_load_req    = 1'b0;
    w_load_pend   = 1'b0;
    w_cancel_exit = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        w_state_nxt = HOLD;
        w_load_req  = 1'b1;
      end
      HOLD: begin
        if (cancel) begin
          w_state_nxt   = GAP;
          w_cancel_exit = 1'b1;
        end else if (r_cnt == '0) begin
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        if (cancel) begin
          w_state_nxt = IDLE;   // slot flushed, ready low: nothing to load
        end else if (w_pend_valid) begin
          w_state_nxt = HOLD;
          w_load_pend = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = HOLD;
          w_load_req  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic: registered outputs are decoded from the next state
  always_comb begin
    {w_src_value, w_src_hold} = w_load_pend ? w_pend_data : {req_value, req_hold};
    w_cnt_init = (w_src_hold == '0) ? '0 : w_src_hold - CNT_W'(1);
    w_force_en_nxt       = (w_state_nxt == HOLD);
    w_done_nxt           = (w_state_nxt == GAP);
    w_done_cancelled_nxt = w_cancel_exit;
    w_force_val_nxt      = (w_load_req || w_load_pend) ? w_src_value : r_force_val;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_force_en       <= 1'b0;
      r_force_val      <= '0;
      r_done           <= 1'b0;
      r_done_cancelled <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_req || w_load_pend)           r_cnt <= w_cnt_init;
      else if (r_state == HOLD && r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      r_force_en       <= w_force_en_nxt;
      r_force_val      <= w_force_val_nxt;
      r_done           <= w_done_nxt;
      r_done_cancelled <= w_done_cancelled_nxt;
    end
  end

  assign force_en       = r_force_en;
  assign force_val      = r_force_val;
  assign done           = r_done;
  assign done_cancelled = r_done_cancelled;
  assign busy           = (r_state != IDLE) || w_pend_valid;

endmodule

// File: doc/override_scheduler.md
Name: override_scheduler

Overview:
- Upstream sequencer for the procedural-override register stage.
- Accepts override requests, each a value plus a hold duration, over a valid/ready handshake.
- Drives force_en/force_val to the downstream register for exactly the requested number of cycles, then releases it for a mandatory one-cycle gap.
- Holds one pending request so back-to-back overrides need no upstream stall.

Parameters:
- WIDTH, 4, width of override value (matches the forced nibble downstream)
- CNT_W, 8, width of hold-duration field

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request can be accepted this cycle
- req_value  input  WIDTH  value to force
- req_hold  input  CNT_W  cycles to hold force; 0 is treated as 1
- cancel  input  1  abort the active override and flush the pending slot
- force_en  output  1  downstream override active (assign when 1, deassign when 0)
- force_val  output  WIDTH  value forced while force_en=1
- busy  output  1  state != IDLE or pending slot valid
- done  output  1  one-cycle pulse at end of each override
- done_cancelled  output  1  valid with done; 1 if the override was ended by cancel

Behaviour:
- Reset (synchronous, active-high, on clock rising edge):
  - state=IDLE; pending slot empty.
  - force_en=0, force_val=0, done=0, done_cancelled=0, busy=0.
  - req_ready=0 while reset is asserted.
- States:
  - IDLE: no override.
  - HOLD: force_en=1.
  - GAP: force_en=0 for exactly one cycle.
- Accept condition: req_valid && req_ready.
  - req_ready = !reset && !pend_valid && !cancel.
- IDLE:
  - Accept in cycle N → HOLD from cycle N+1; force_val=req_value.
  - Load counter with max(req_hold,1)-1.
  - The request bypasses the pending slot.
- HOLD:
  - force_en=1 for exactly max(req_hold,1) consecutive cycles.
  - Counter decrements each cycle; when it reaches 0, next state is GAP.
  - A request accepted during HOLD goes to the pending slot.
- GAP:
  - force_en=0; force_val keeps its last value.
  - done=1; done_cancelled reflects the exit cause.
  - Next state is HOLD if the pending slot is valid, or a request is accepted in this GAP cycle (same-cycle bypass). Otherwise IDLE.
  - When loading from pending, the slot is cleared that cycle.
- Back-to-back overrides are always separated by exactly one force_en=0 cycle. The downstream register must observe the release between overrides.
- cancel:
  - In HOLD: next state GAP regardless of counter; pending slot flushed; done_cancelled=1 in that GAP.
  - In IDLE or GAP: flushes the pending slot only; GAP still proceeds to IDLE because req_ready=0 that cycle.
  - cancel always has priority over acceptance.
- Counter arithmetic: unsigned CNT_W. Maximum hold is 2^CNT_W-1 cycles. No wrap: the counter stops at 0.
- Reset mid-HOLD: force_en drops to 0 in the cycle after reset is sampled. No done pulse is generated.
- busy is combinational from state and pend_valid.
- All other outputs are registered.

Decomposition:
- Package override_pkg holds:
  - state enum: IDLE/HOLD/GAP, 2 bits
  - constants OVR_WIDTH_DEF=4, OVR_CNT_W_DEF=8
  - request struct {value, hold}
- Sub-module override_pend_slot: one-entry holding register with load/flush/take and valid flag.
- FSM and counter stay in the top module.

Test Plan:
1. Reset then single request value=4'h2, hold=3, accepted at cycle 10:
   - force_en=1, force_val=2 in cycles 11–13.
   - force_en=0 and done=1 with done_cancelled=0 in cycle 14.
   - IDLE in cycle 15; busy=0.
2. hold=0, value=4'h5:
   - force_en high exactly 1 cycle, then GAP with done.
3. Back-to-back: request A (value=1, hold=2), then B (value=7, hold=2) presented during A's HOLD:
   - B accepted into the pending slot; req_ready=0 until the slot empties.
   - Waveform: force_en 1,1,0,1,1,0; force_val 1 then 7; two done pulses.
4. cancel in the 2nd cycle of a hold=10 override with a pending request:
   - Next cycle GAP with done=1 and done_cancelled=1.
   - Pending request is discarded; then IDLE.
5. Request presented in the same cycle as GAP (pending empty):
   - Accepted via bypass; force_en re-asserts the cycle after GAP.
6. reset asserted mid-HOLD (hold=20, cycle 5):
   - All outputs 0 the next cycle, no done pulse, req_ready=0 during reset.
   - After release, a new request is handled normally.
